// File: rtl/fir_mac_sequencer.sv
// Control FSM for a time-multiplexed FIR: one shared MAC, TAPS cycles per output.
// Optional FIR_SEQ_PERF_CNT_EN adds result_cnt and overrun_flag.
module fir_mac_sequencer #(
  parameter int TAPS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_en,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [1:0]        add_sel,
  output logic              out_load,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FIR_SEQ_PERF_CNT_EN
  output logic [15:0]       result_cnt,
  output logic              overrun_flag,
`endif
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_MAC  = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_WB,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              shift_en_q, shift_en_d;
  logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
  logic              acc_clr_q, acc_clr_d;
  logic              acc_en_q, acc_en_d;
  logic [1:0]        add_sel_q, add_sel_d;
  logic              out_load_q, out_load_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_LOAD;
      S_LOAD: state_d = S_MAC;
      S_MAC: begin
        if (cnt_q == LAST) state_d = S_WB;
        else cnt_d = cnt_q + ADDR_W'(1);
      end
      S_WB:   state_d = S_HOLD;
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are flop outputs.
  always_comb begin
    shift_en_d  = (state_d == S_LOAD);
    acc_clr_d   = (state_d == S_LOAD);
    acc_en_d    = (state_d == S_MAC);
    out_load_d  = (state_d == S_WB);
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
    coef_addr_d = acc_en_d ? cnt_d : '0;
    add_sel_d   = SEL_HOLD;
    unique case (1'b1)
      shift_en_d: add_sel_d = SEL_ZERO;
      acc_en_d:   add_sel_d = SEL_MAC;
      default:    add_sel_d = SEL_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_en_q  <= 1'b0;
      coef_addr_q <= '0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      add_sel_q   <= SEL_HOLD;
      out_load_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_en_q  <= shift_en_d;
      coef_addr_q <= coef_addr_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
      add_sel_q   <= add_sel_d;
      out_load_q  <= out_load_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign shift_en  = shift_en_q;
  assign coef_addr = coef_addr_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign add_sel   = add_sel_q;
  assign out_load  = out_load_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

`ifdef FIR_SEQ_PERF_CNT_EN
  logic [15:0] result_cnt_q, result_cnt_d;
  logic        overrun_q, overrun_d;

  always_comb begin
    result_cnt_d = result_cnt_q;
    if (out_valid_q && out_ready) result_cnt_d = result_cnt_q + 16'd1;
    // A source pushing while the sink stalls the result is flagged.
    overrun_d = overrun_q | (out_valid_q & in_valid & ~out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_cnt_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      result_cnt_q <= result_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign result_cnt   = result_cnt_q;
  assign overrun_flag = overrun_q;
`endif

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control FSM for the time-multiplexed FIR datapath: one shared multiply-accumulate stage, a sample shift register, a coefficient ROM, and the select-driven muxes around the accumulator. The block accepts one input sample per valid/ready handshake and drives the datapath through TAPS MAC cycles. It then loads the output register and holds the result under a valid/ready handshake. It sits between the sample source and the FIR datapath and generates every mux select and enable that the datapath consumes.

Parameters:
TAPS, 8, number of filter taps = MAC cycles per output; legal range 1..2^ADDR_W
ADDR_W, 3, width of coefficient/tap address

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  source has a sample on the datapath input bus
in_ready  output  1  sequencer can accept a sample
shift_en  output  1  shift sample register, insert new sample
coef_addr  output  ADDR_W  tap/coefficient index for the current MAC cycle
acc_clr  output  1  clear accumulator
acc_en  output  1  accumulator register load enable
add_sel  output  2  accumulator adder input mux select: 00 zero, 01 product+acc, 10 acc hold, 11 unused
out_load  output  1  load output register from accumulator
out_valid  output  1  output register holds an unconsumed result
out_ready  input  1  sink accepts result
busy  output  1  high in any state other than IDLE

Behaviour:
- All control outputs except in_ready are registered (Moore, decoded into flops). in_ready = (state==IDLE) & ~rst.
- Reset, synchronous and active-high: state=IDLE, tap counter=0, and all outputs 0 (shift_en, coef_addr, acc_clr, acc_en, out_load, out_valid, busy, add_sel=10). Reset mid-operation aborts immediately. The accumulator result is discarded and no out_valid follows.
- States:
  - IDLE: in_ready=1. Accept on (in_valid & in_ready) at edge k. Go to LOAD.
  - LOAD (cycle k+1): shift_en=1, acc_clr=1, add_sel=00, coef_addr=0. Go to MAC.
  - MAC (cycles k+2 .. k+TAPS+1): acc_en=1, add_sel=01, coef_addr = tap counter 0..TAPS-1, incrementing by 1 per cycle. When counter==TAPS-1, go to WB. The counter never wraps past TAPS-1 and resets to 0 on exit.
  - WB (cycle k+TAPS+2): out_load=1, acc_en=0, add_sel=10. Go to HOLD.
  - HOLD (from cycle k+TAPS+3): out_valid=1. When out_valid & out_ready at an edge, go to IDLE. out_valid is 0 and in_ready is 1 in the following cycle.
- Latency from input accept edge to out_valid high: TAPS+3 cycles. Throughput: one sample per TAPS+4 cycles, assuming out_ready is tied high.
- Outside their listed states: shift_en, acc_clr, acc_en and out_load are 0, add_sel=10, and coef_addr=0.
- in_valid is ignored outside IDLE; no sample is lost or double-shifted. A source holding in_valid through a computation is accepted again only after HOLD completes.
- Backpressure: HOLD persists indefinitely while out_ready=0. Datapath enables stay 0, so the accumulator and output register are stable.
- TAPS=1: MAC lasts exactly one cycle, with coef_addr=0.
- busy=1 in LOAD, MAC, WB and HOLD.

Optional Feature:
FIR_SEQ_PERF_CNT_EN
- Defined: adds output port result_cnt [15:0]. It resets to 0 and increments by 1 on each out_valid & out_ready handshake, wrapping 16'hFFFF -> 0. It also adds output overrun_flag, a sticky flag set when in_valid=1 during HOLD with out_ready=0; it is cleared only by rst.
- Undefined: neither port exists and there are no counter flops. All other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> all outputs 0, in_ready=0 during reset. First cycle after release: in_ready=1, busy=0.
- Single sample, TAPS=8, out_ready=1: accept at edge 0 -> shift_en and acc_clr at cycle 1. acc_en=1 at cycles 2..9 with coef_addr 0,1,...,7. out_load at cycle 10. out_valid at cycle 11, low at cycle 12, in_ready=1 at cycle 12.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD -> out_valid stays 1, in_ready stays 0, no shift_en or acc_en pulse. Raise out_ready -> one handshake, then IDLE.
- Continuous in_valid=1, out_ready=1, 3 samples -> exactly 3 shift_en pulses, spaced 12 cycles apart, and exactly 3 out_valid handshakes.
- Reset mid-MAC (coef_addr=4): rst for 1 cycle -> next cycle all outputs 0, no out_load or out_valid. A new accept restarts with coef_addr=0.
- TAPS=1 build: accept -> acc_en for exactly 1 cycle with coef_addr=0, out_valid 4 cycles after accept. With FIR_SEQ_PERF_CNT_EN defined: result_cnt=1 after the handshake.
